vdp_super_res_palette: RTL and testbench

- 256-entry, 24-bit RGB palette that sits directly downstream of the super-res pixel fetch stage.
- Video side: consumes the 8-bit palette index the fetch stage issues every clk and returns 8-bit R/G/B with one-cycle latency.
- CPU side: accepts byte-serial palette writes (index, then R, G, B) from the register-port decoder.
- Holds a reset-time initialiser that loads a default grey ramp, so super-res output is defined before software programs the palette.

---
 rtl/vdp_super_pkg.sv | 33 +++
 rtl/vdp_super_res_palette_if.sv | 31 +++
 rtl/vdp_palette_ram.sv | 38 +++
 rtl/vdp_super_res_palette.sv | 144 ++++++++++++++
 tb/tb_vdp_super_res_palette.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_super_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vdp_super_pkg                                                     |
// | Brief   : Shared types/constants for the super-res video path.              |
// | Rev     : 1.0  initial palette types                                        |
// +----------------------------------------------------------------------------+
package vdp_super_pkg;

  localparam int PAL_ENTRIES = 256;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } pal_phase_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } pal_init_state_t;

  function automatic rgb24_t grey_entry(input logic [7:0] n);
    grey_entry = rgb24_t'{r: n, g: n, b: n};
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_super_res_palette_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vdp_super_res_palette_if                                          |
// | Brief   : Video read path and CPU byte-write port of the super-res palette. |
// | Rev     : 1.0  initial interface                                            |
// +----------------------------------------------------------------------------+
interface vdp_super_res_palette_if #(
  parameter int IDX_W = 8
);
  logic             vdp_super;
  logic [IDX_W-1:0] pal_rd_addr;
  logic [7:0]       pal_r;
  logic [7:0]       pal_g;
  logic [7:0]       pal_b;
  logic             cpu_idx_wr;
  logic             cpu_dat_wr;
  logic [7:0]       cpu_data;
  logic             busy;
  logic [IDX_W-1:0] wr_index;

  modport master (
    output vdp_super, pal_rd_addr, cpu_idx_wr, cpu_dat_wr, cpu_data,
    input  pal_r, pal_g, pal_b, busy, wr_index
  );

  modport slave (
    input  vdp_super, pal_rd_addr, cpu_idx_wr, cpu_dat_wr, cpu_data,
    output pal_r, pal_g, pal_b, busy, wr_index
  );
endinterface
`default_nettype wire

// File: rtl/vdp_palette_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vdp_palette_ram                                                   |
// | Brief   : Simple dual-port RAM, registered read, read-before-write.         |
// | Rev     : 1.0  initial                                                      |
// +----------------------------------------------------------------------------+
module vdp_palette_ram
  import vdp_super_pkg::*;
#(
  parameter int DEPTH  = PAL_ENTRIES,
  parameter int ADDR_W = 8
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] wr_addr,
  input  wire logic [23:0]       wr_data,
  input  wire logic [ADDR_W-1:0] rd_addr,
  output logic      [23:0]       rd_data
);

  // No reset on the array or read register so the tools map this onto block RAM.
  logic [23:0] r_mem [DEPTH];
  logic [23:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    r_rd_data <= r_mem[rd_addr];
  end

  assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/vdp_super_res_palette.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vdp_super_res_palette                                             |
// | Brief   : 256x24 palette with grey-ramp initialiser and CPU byte writer.    |
// | Rev     : 1.0  initial                                                      |
// +----------------------------------------------------------------------------+
module vdp_super_res_palette
  import vdp_super_pkg::*;
#(
  parameter int ENTRIES       = PAL_ENTRIES,
  parameter int IDX_W         = 8,
  parameter int INIT_ON_RESET = 1
) (
  input wire logic               clk,
  input wire logic               reset,
  vdp_super_res_palette_if.slave bus
);

  localparam pal_init_state_t  C_RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
  localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(ENTRIES - 1);

  pal_init_state_t  r_state;
  pal_init_state_t  w_state_nxt;
  logic [IDX_W-1:0] r_init_cnt;
  logic [IDX_W-1:0] w_init_cnt_nxt;
  logic             w_init_we;

  pal_phase_t       r_phase;
  logic [IDX_W-1:0] r_wr_index;
  logic [7:0]       r_r_hold;
  logic [7:0]       r_g_hold;
  logic             w_cpu_active;
  logic             w_cpu_commit;

  logic             w_ram_we;
  logic [IDX_W-1:0] w_ram_waddr;
  rgb24_t           w_ram_wdata;
  rgb24_t           w_ram_q;
  logic             r_out_en;

  // ---------------- initialiser FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= C_RST_STATE;
      r_init_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    w_init_we      = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_we      = 1'b1;
        w_init_cnt_nxt = r_init_cnt + 1'b1;
        if (r_init_cnt == C_LAST_IDX) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
      end
    endcase
  end

  // ---------------- CPU byte sequencer ----------------
  assign w_cpu_active = (r_state == ST_IDLE);
  // An index strobe in the same clk swallows the data byte, so it can never commit.
  assign w_cpu_commit = w_cpu_active && !bus.cpu_idx_wr && bus.cpu_dat_wr && (r_phase == PH_B);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase    <= PH_R;
      r_wr_index <= '0;
      r_r_hold   <= 8'h00;
      r_g_hold   <= 8'h00;
    end else if (w_cpu_active) begin
      if (bus.cpu_idx_wr) begin
        r_wr_index <= IDX_W'(bus.cpu_data);
        r_phase    <= PH_R;
      end else if (bus.cpu_dat_wr) begin
        case (r_phase)
          PH_R: begin
            r_r_hold <= bus.cpu_data;
            r_phase  <= PH_G;
          end
          PH_G: begin
            r_g_hold <= bus.cpu_data;
            r_phase  <= PH_B;
          end
          default: begin
            r_wr_index <= r_wr_index + 1'b1;
            r_phase    <= PH_R;
          end
        endcase
      end
    end
  end

  // ---------------- RAM write mux (initialiser wins) ----------------
  always_comb begin
    w_ram_we    = w_init_we | w_cpu_commit;
    w_ram_waddr = r_wr_index;
    w_ram_wdata = rgb24_t'{r: r_r_hold, g: r_g_hold, b: bus.cpu_data};
    if (w_init_we) begin
      w_ram_waddr = r_init_cnt;
      w_ram_wdata = grey_entry(8'(r_init_cnt));
    end
  end

  vdp_palette_ram #(
    .DEPTH  (ENTRIES),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we      (w_ram_we),
    .wr_addr (w_ram_waddr),
    .wr_data (w_ram_wdata),
    .rd_addr (bus.pal_rd_addr),
    .rd_data (w_ram_q)
  );

  // ---------------- video output ----------------
  // The RAM read register is the only pipeline stage; this flag zeroes it
  // for the same clk when super-res is off or during reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_en <= 1'b0;
    end else begin
      r_out_en <= bus.vdp_super;
    end
  end

  assign bus.pal_r    = r_out_en ? w_ram_q.r : 8'h00;
  assign bus.pal_g    = r_out_en ? w_ram_q.g : 8'h00;
  assign bus.pal_b    = r_out_en ? w_ram_q.b : 8'h00;
  assign bus.busy     = (r_state == ST_INIT);
  assign bus.wr_index = r_wr_index;

endmodule
`default_nettype wire

// File: tb/tb_vdp_super_res_palette.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vdp_super_res_palette                                          |
// | Brief   : Directed bench with a behavioural palette model and scoreboard.   |
// | Rev     : 1.0  initial                                                      |
// +----------------------------------------------------------------------------+
module tb_vdp_super_res_palette;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vdp_super_res_palette_if #(.IDX_W(8)) bus ();

  vdp_super_res_palette #(
    .ENTRIES       (256),
    .IDX_W         (8),
    .INIT_ON_RESET (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, required %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_ram   [256];
  bit          m_known [256];
  int          m_init_left = 0;
  logic [7:0]  m_wr        = 8'h00;
  int          m_nbytes    = 0;
  logic [7:0]  m_bytes [3];
  logic [23:0] m_exp       = 24'h0;
  bit          m_exp_valid = 1'b0;
  bit          m_live      = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_init_left = 256;
        m_wr        = 8'h00;
        m_nbytes    = 0;
        m_exp       = 24'h0;
        m_exp_valid = 1'b1;
        m_live      = 1'b1;
      end else begin
        logic [7:0] a;
        a = bus.pal_rd_addr;
        if (!bus.vdp_super) begin
          m_exp       = 24'h0;
          m_exp_valid = 1'b1;
        end else begin
          m_exp       = m_ram[a];
          m_exp_valid = m_known[a];
        end
        if (m_init_left > 0) begin
          logic [7:0] n;
          n = 8'(256 - m_init_left);
          m_ram[n]   = {n, n, n};
          m_known[n] = 1'b1;
          m_init_left--;
        end else if (bus.cpu_idx_wr) begin
          m_wr     = bus.cpu_data;
          m_nbytes = 0;
        end else if (bus.cpu_dat_wr) begin
          m_bytes[m_nbytes] = bus.cpu_data;
          m_nbytes++;
          if (m_nbytes == 3) begin
            m_ram[m_wr]   = {m_bytes[0], m_bytes[1], m_bytes[2]};
            m_known[m_wr] = 1'b1;
            m_wr          = m_wr + 8'd1;
            m_nbytes      = 0;
          end
        end
      end
    end
  end

  // Scoreboard compare on the falling edge, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("sb_busy", {23'h0, bus.busy}, {23'h0, (m_init_left > 0)});
        check("sb_wr_index", {16'h0, bus.wr_index}, {16'h0, m_wr});
        if (m_exp_valid) check("sb_pal", {bus.pal_r, bus.pal_g, bus.pal_b}, m_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idx(input logic [7:0] d);
    bus.cpu_idx_wr = 1'b1;
    bus.cpu_data   = d;
    tick();
    bus.cpu_idx_wr = 1'b0;
  endtask

  task automatic dat(input logic [7:0] d);
    bus.cpu_dat_wr = 1'b1;
    bus.cpu_data   = d;
    tick();
    bus.cpu_dat_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [23:0] exp, input string nm);
    bus.pal_rd_addr = a;
    tick();
    check(nm, {bus.pal_r, bus.pal_g, bus.pal_b}, exp);
  endtask

  initial begin
    bus.vdp_super   = 1'b1;
    bus.pal_rd_addr = 8'h00;
    bus.cpu_idx_wr  = 1'b0;
    bus.cpu_dat_wr  = 1'b0;
    bus.cpu_data    = 8'h00;

    repeat (3) tick();
    check("rst_pal", {bus.pal_r, bus.pal_g, bus.pal_b}, 24'h000000);
    check("rst_busy", {23'h0, bus.busy}, 24'h1);
    check("rst_wr_index", {16'h0, bus.wr_index}, 24'h0);
    reset = 1'b0;

    // Strobes while busy must be ignored.
    idx(8'h55);
    dat(8'h66);
    dat(8'h77);
    dat(8'h88);
    repeat (251) tick();
    check("busy_at_255", {23'h0, bus.busy}, 24'h1);
    check("wr_index_busy", {16'h0, bus.wr_index}, 24'h0);
    tick();
    check("busy_at_256", {23'h0, bus.busy}, 24'h0);

    rd(8'h80, 24'h808080, "init_80");
    rd(8'hFF, 24'hFFFFFF, "init_ff");

    idx(8'h10);
    dat(8'h11); dat(8'h22); dat(8'h33);
    rd(8'h10, 24'h112233, "wr_10");
    check("wr_index_11", {16'h0, bus.wr_index}, 24'h11);
    dat(8'h44); dat(8'h55); dat(8'h66);
    rd(8'h11, 24'h445566, "wr_11");

    idx(8'hFF);
    dat(8'hAA); dat(8'hBB); dat(8'hCC);
    dat(8'h01); dat(8'h02); dat(8'h03);
    rd(8'hFF, 24'hAABBCC, "wr_ff");
    rd(8'h00, 24'h010203, "wrap_00");
    check("wr_index_wrap", {16'h0, bus.wr_index}, 24'h01);

    idx(8'h20);
    dat(8'h7A); dat(8'h7B);
    bus.pal_rd_addr = 8'h20;
    dat(8'h7C);
    check("collide_old", {bus.pal_r, bus.pal_g, bus.pal_b}, 24'h202020);
    tick();
    check("collide_new", {bus.pal_r, bus.pal_g, bus.pal_b}, 24'h7A7B7C);

    idx(8'h40);
    dat(8'h99); dat(8'h98);
    idx(8'h40);
    rd(8'h40, 24'h404040, "partial_kept");
    dat(8'h01); dat(8'h02); dat(8'h03);
    rd(8'h40, 24'h010203, "phase_r");

    bus.cpu_idx_wr = 1'b1;
    bus.cpu_dat_wr = 1'b1;
    bus.cpu_data   = 8'h50;
    tick();
    bus.cpu_idx_wr = 1'b0;
    bus.cpu_dat_wr = 1'b0;
    dat(8'hA1); dat(8'hA2); dat(8'hA3);
    rd(8'h50, 24'hA1A2A3, "idx_wins");
    check("wr_index_51", {16'h0, bus.wr_index}, 24'h51);

    bus.pal_rd_addr = 8'h50;
    bus.vdp_super   = 1'b0;
    tick();
    check("super_off", {bus.pal_r, bus.pal_g, bus.pal_b}, 24'h000000);
    idx(8'h60);
    dat(8'h12); dat(8'h34); dat(8'h56);
    bus.vdp_super = 1'b1;
    rd(8'h60, 24'h123456, "write_while_off");

    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (100) tick();
    reset = 1'b1;
    tick();
    check("rst_mid_init_wr", {16'h0, bus.wr_index}, 24'h0);
    reset = 1'b0;
    repeat (255) tick();
    check("restart_busy_255", {23'h0, bus.busy}, 24'h1);
    tick();
    check("restart_busy_256", {23'h0, bus.busy}, 24'h0);
    rd(8'h10, 24'h101010, "reinit_10");
    rd(8'h60, 24'h606060, "reinit_60");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
